pipe_fetch_unit: RTL

//  IF stage plus IF/ID pipeline register of the 5-stage pipelined MIPS CPU.

---
 rtl/pipe_pkg.sv | 18 +
 rtl/pipe_npc_sel.sv | 33 +++
 rtl/pipe_fetch_unit.sv | 108 ++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipelined MIPS front end: PC-source codes,
// the nop encoding and the fetch FSM state type.
package pipe_pkg;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JR  = 2'b10;
  localparam logic [1:0] PCSRC_J   = 2'b11;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/pipe_npc_sel.sv
// Next-PC selection: decodes an ID-stage redirect and muxes the target
// in front of the sequential next_pc.
module pipe_npc_sel
  import pipe_pkg::*;
(
  input  logic        id_valid,
  input  logic        nostall,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  input  logic [31:0] next_pc,
  output logic        redirect,
  output logic [31:0] pc_sel
);

  logic [31:0] tgt;

  always_comb begin
    tgt = next_pc;
    case (pcsource)
      PCSRC_BR: tgt = bpc;
      PCSRC_JR: tgt = rpc;
      PCSRC_J:  tgt = jpc;
      default:  tgt = next_pc;
    endcase
  end

  // Only a real instruction that is leaving ID may steer the PC.
  assign redirect = id_valid & nostall & (pcsource != PCSRC_SEQ);
  assign pc_sel   = redirect ? tgt : next_pc;

endmodule

// File: rtl/pipe_fetch_unit.sv
// IF stage and IF/ID register: PC state, variable-latency instruction fetch
// with a one-word skid for ID stalls, and delay-slot redirect handling.
module pipe_fetch_unit
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        nostall,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] dpc4,
  output logic        id_valid
);

  fetch_state_t state;
  logic [31:0]  fetch_pc;
  logic [31:0]  next_pc;
  logic [31:0]  skid;
  logic         redirect;
  logic [31:0]  pc_sel;
  logic         accept;
  logic         fetch_hit;
  logic         done;

  assign accept    = ~id_valid | nostall;
  assign fetch_hit = (state == S_FETCH) & imem_ready;
  // The PC advances only when a word actually enters IF/ID, so a parked word
  // in the skid still pairs with fetch_pc when it is finally delivered.
  assign done      = (fetch_hit & accept) | ((state == S_HOLD) & nostall);
  assign imem_addr = fetch_pc;

  pipe_npc_sel u_npc_sel (
    .id_valid (id_valid),
    .nostall  (nostall),
    .pcsource (pcsource),
    .bpc      (bpc),
    .rpc      (rpc),
    .jpc      (jpc),
    .next_pc  (next_pc),
    .redirect (redirect),
    .pc_sel   (pc_sel)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= S_BOOT;
      fetch_pc <= RESET_PC;
      next_pc  <= RESET_PC + 32'd4;
      skid     <= NOP_INST;
      inst     <= NOP_INST;
      dpc4     <= 32'd0;
      id_valid <= 1'b0;
      imem_req <= 1'b0;
    end else begin
      // A redirect seen while the delay slot is still in flight waits in next_pc.
      if (done) begin
        fetch_pc <= pc_sel;
        next_pc  <= pc_sel + 32'd4;
      end else begin
        next_pc  <= pc_sel;
      end

      case (state)
        S_BOOT: begin
          state    <= S_FETCH;
          imem_req <= 1'b1;
        end
        S_FETCH: begin
          if (fetch_hit && !accept) begin
            skid     <= imem_rdata;
            state    <= S_HOLD;
            imem_req <= 1'b0;
          end
        end
        S_HOLD: begin
          if (nostall) begin
            state    <= S_FETCH;
            imem_req <= 1'b1;
          end
        end
        default: begin
          state    <= S_BOOT;
          imem_req <= 1'b0;
        end
      endcase

      if (done) begin
        inst     <= (state == S_HOLD) ? skid : imem_rdata;
        dpc4     <= fetch_pc + 32'd4;
        id_valid <= 1'b1;
      end else if (accept) begin
        inst     <= NOP_INST;
        dpc4     <= 32'd0;
        id_valid <= 1'b0;
      end
    end
  end

endmodule
